// File: rtl/prm_edge_mask_accum.sv
// prm_edge_mask_accum
// Collects the per-edge obstacle mask over every obstacle voxel of a frame.
// The result is a blocked-edge bitmap for the PRM graph. The bitmap is then
// read out as WORD_W-bit words over a valid/ready port, and the blocked edges
// are counted as the words are accepted.
module prm_edge_mask_accum #(
   parameter int NUM_EDGES = 256,
   parameter int WORD_W    = 32,
   parameter int CNT_W     = 16,
   localparam int NUM_WORDS = (NUM_EDGES + WORD_W - 1) / WORD_W,
   localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int BC_W      = $clog2(NUM_EDGES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 vox_valid,
   input  logic                 vox_last,
   input  logic [NUM_EDGES-1:0] edge_mask_in,
   output logic                 busy,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [WORD_W-1:0]    rd_data,
   output logic [IDX_W-1:0]     rd_index,
   output logic                 done,
   output logic [BC_W-1:0]      blocked_count,
   output logic [CNT_W-1:0]     vox_count,
   output logic                 err_overrun
);

   localparam int PAD_W = NUM_WORDS * WORD_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_reg;
   logic [NUM_EDGES-1:0]  bitmap_reg;
   logic                  busy_reg;
   logic                  rd_valid_reg;
   logic [WORD_W-1:0]     rd_data_reg;
   logic [IDX_W-1:0]      rd_index_reg;
   logic                  done_reg;
   logic [BC_W-1:0]       blocked_count_reg;
   logic [CNT_W-1:0]      vox_count_reg;
   logic                  err_overrun_reg;

   // Bits above NUM_EDGES are zero-padded so the last word reads 0 there.
   logic [PAD_W-1:0]      bitmap_pad;
   logic [PAD_W-1:0]      merged_pad;
   logic [WORD_W-1:0]     bitmap_words [NUM_WORDS];
   logic [IDX_W-1:0]      rd_index_next;
   logic                  last_word;
   logic                  vox_sat;
   logic [BC_W-1:0]       word_pop;

   assign bitmap_pad    = PAD_W'(bitmap_reg);
   assign merged_pad    = PAD_W'(bitmap_reg | edge_mask_in);
   assign rd_index_next = rd_index_reg + IDX_W'(1);
   assign last_word     = (rd_index_reg == IDX_W'(NUM_WORDS - 1));
   assign vox_sat       = &vox_count_reg;

   // Slice the padded bitmap into readout words.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
         assign bitmap_words[gi] = bitmap_pad[gi*WORD_W +: WORD_W];
      end
   endgenerate

   function automatic logic [BC_W-1:0] popcount(input logic [WORD_W-1:0] w);
      logic [BC_W-1:0] c;
      c = '0;
      for (int i = 0; i < WORD_W; i++) begin
         c = c + BC_W'(w[i]);
      end
      return c;
   endfunction

   // Number of ones in the word currently presented on rd_data.
   always_comb begin
      word_pop = popcount(rd_data_reg);
   end

   // Frame control: accumulate, drain, then pulse done. Start restarts from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= S_IDLE;
         bitmap_reg        <= '0;
         busy_reg          <= 1'b0;
         rd_valid_reg      <= 1'b0;
         rd_data_reg       <= '0;
         rd_index_reg      <= '0;
         done_reg          <= 1'b0;
         blocked_count_reg <= '0;
         vox_count_reg     <= '0;
         err_overrun_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            // Abort whatever is in flight. A coincident voxel beat is dropped.
            state_reg         <= S_ACCUM;
            bitmap_reg        <= '0;
            busy_reg          <= 1'b1;
            rd_valid_reg      <= 1'b0;
            rd_data_reg       <= '0;
            rd_index_reg      <= '0;
            blocked_count_reg <= '0;
            vox_count_reg     <= '0;
            err_overrun_reg   <= 1'b0;
         end else begin
            if (vox_valid && (state_reg != S_ACCUM)) begin
               err_overrun_reg <= 1'b1;
            end
            case (state_reg)
               S_IDLE: begin
               end
               S_ACCUM: begin
                  if (vox_valid) begin
                     bitmap_reg <= bitmap_reg | edge_mask_in;
                     if (!vox_sat) begin
                        vox_count_reg <= vox_count_reg + CNT_W'(1);
                     end
                     if (vox_last) begin
                        // Word 0 must already include this final beat.
                        state_reg    <= S_DRAIN;
                        rd_valid_reg <= 1'b1;
                        rd_index_reg <= '0;
                        rd_data_reg  <= merged_pad[WORD_W-1:0];
                     end
                  end
               end
               S_DRAIN: begin
                  if (rd_valid_reg && rd_ready) begin
                     blocked_count_reg <= blocked_count_reg + word_pop;
                     if (last_word) begin
                        state_reg    <= S_DONE;
                        rd_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                     end else begin
                        rd_index_reg <= rd_index_next;
                        rd_data_reg  <= bitmap_words[rd_index_next];
                     end
                  end
               end
               S_DONE: begin
                  state_reg <= S_IDLE;
               end
               default: begin
                  state_reg <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign busy          = busy_reg;
   assign rd_valid      = rd_valid_reg;
   assign rd_data       = rd_data_reg;
   assign rd_index      = rd_index_reg;
   assign done          = done_reg;
   assign blocked_count = blocked_count_reg;
   assign vox_count     = vox_count_reg;
   assign err_overrun   = err_overrun_reg;

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Testbench for prm_edge_mask_accum.
// Stimulus pushes the expected words and per-frame totals into queues.
// A negedge monitor checks the DUT against those queues.
// A second instance with a 4-bit voxel counter exercises saturation.
module tb_prm_edge_mask_accum;

   localparam int NE = 256;
   localparam int WW = 32;
   localparam int NW = 8;

   typedef struct {
      logic [WW-1:0] data;
      logic [2:0]    idx;
   } word_t;

   typedef struct {
      int blocked;
      int vox;
      int vox_sat;
   } sum_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          vox_valid;
   logic          vox_last;
   logic [NE-1:0] edge_mask_in;
   logic          rd_ready;

   logic          busy, rd_valid, done, err_overrun;
   logic [WW-1:0] rd_data;
   logic [2:0]    rd_index;
   logic [8:0]    blocked_count;
   logic [15:0]   vox_count;

   logic          s_busy, s_rd_valid, s_done, s_err_overrun;
   logic [WW-1:0] s_rd_data;
   logic [2:0]    s_rd_index;
   logic [8:0]    s_blocked_count;
   logic [3:0]    s_vox_count;

   int            tests = 0;
   int            fails = 0;
   word_t         exp_q[$];
   sum_t          sum_q[$];
   logic [NE-1:0] model_bm;
   int            model_cnt;
   int            ready_mode = 0;
   int            rdy_phase = 0;
   word_t         mon_e;
   sum_t          mon_s;

   always #5 clk = ~clk;

   prm_edge_mask_accum #(.NUM_EDGES(NE), .WORD_W(WW), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .vox_valid(vox_valid), .vox_last(vox_last),
      .edge_mask_in(edge_mask_in), .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_index(rd_index), .done(done), .blocked_count(blocked_count),
      .vox_count(vox_count), .err_overrun(err_overrun)
   );

   prm_edge_mask_accum #(.NUM_EDGES(NE), .WORD_W(WW), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .start(start), .vox_valid(vox_valid), .vox_last(vox_last),
      .edge_mask_in(edge_mask_in), .busy(s_busy), .rd_valid(s_rd_valid), .rd_ready(rd_ready),
      .rd_data(s_rd_data), .rd_index(s_rd_index), .done(s_done), .blocked_count(s_blocked_count),
      .vox_count(s_vox_count), .err_overrun(s_err_overrun)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [NE-1:0] onehot(input int b);
      logic [NE-1:0] v;
      v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [NE-1:0] rand_mask(input bit sparse);
      logic [NE-1:0] v;
      for (int i = 0; i < NW; i++) begin
         v[i*WW +: WW] = sparse ? ($urandom() & $urandom() & $urandom()) : $urandom();
      end
      return v;
   endfunction

   // Monitor: compare presented words and frame totals with the expectation queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sum_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL done_unexpected: got done=1, required done=0");
            end else begin
               mon_s = sum_q.pop_front();
               check("blocked_count", 64'(blocked_count), 64'(mon_s.blocked));
               check("vox_count", 64'(vox_count), 64'(mon_s.vox));
               check("vox_count_sat4", 64'(s_vox_count), 64'(mon_s.vox_sat));
               check("sat_done", 64'(s_done), 64'd1);
               check("busy_at_done", 64'(busy), 64'd0);
               check("words_left_at_done", 64'(exp_q.size()), 64'd0);
               $display("[TB] frame done blocked=%0d vox=%0d sat_vox=%0d",
                        blocked_count, vox_count, s_vox_count);
            end
         end
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL word_unexpected: got rd_valid=1 idx=%0d, required rd_valid=0", rd_index);
            end else begin
               mon_e = exp_q[0];
               check("rd_data", 64'(rd_data), 64'(mon_e.data));
               check("rd_index", 64'(rd_index), 64'(mon_e.idx));
               check("sat_rd_valid", 64'(s_rd_valid), 64'd1);
               check("sat_rd_data", 64'(s_rd_data), 64'(mon_e.data));
               if (rd_ready) begin
                  void'(exp_q.pop_front());
                  $display("[TB] word %0d accepted data=%08h", rd_index, rd_data);
               end
            end
         end
      end
   end

   // rd_ready driver: always-ready, fixed 1,0,0,1 pattern, or random.
   initial begin
      rd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: rd_ready = 1'b1;
            1: begin
               rd_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
               rdy_phase++;
            end
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expect();
      sum_t s;
      for (int w = 0; w < NW; w++) begin
         exp_q.push_back('{data: model_bm[w*WW +: WW], idx: 3'(w)});
      end
      s.blocked = $countones(model_bm);
      s.vox     = model_cnt;
      s.vox_sat = (model_cnt > 15) ? 15 : model_cnt;
      sum_q.push_back(s);
   endtask

   task automatic begin_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      model_bm  = '0;
      model_cnt = 0;
   endtask

   task automatic beat(input logic [NE-1:0] m, input bit last);
      vox_valid    = 1'b1;
      vox_last     = last;
      edge_mask_in = m;
      tick();
      vox_valid    = 1'b0;
      vox_last     = 1'b0;
      edge_mask_in = rand_mask(1'b0);
      model_bm     = model_bm | m;
      model_cnt++;
      if (last) push_expect();
   endtask

   // A cycle with no voxel; vox_last may toggle and must be ignored.
   task automatic gap();
      vox_last     = 1'($urandom_range(0, 1));
      edge_mask_in = rand_mask(1'b0);
      tick();
      vox_last = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0 && sum_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      check("drain_completed", 64'(ok), 64'd1);
      exp_q.delete();
      sum_q.delete();
   endtask

   task automatic random_frame(input int nbeats, input bit sparse);
      begin_frame();
      for (int b = 0; b < nbeats; b++) begin
         if ($urandom_range(0, 3) == 0) gap();
         beat(rand_mask(sparse), b == nbeats - 1);
      end
      wait_drain();
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      vox_valid    = 1'b0;
      vox_last     = 1'b0;
      edge_mask_in = '0;
      model_bm     = '0;
      model_cnt    = 0;
      repeat (3) tick();

      // Reset values
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_rd_index", 64'(rd_index), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_blocked_count", 64'(blocked_count), 64'd0);
      check("rst_vox_count", 64'(vox_count), 64'd0);
      check("rst_err_overrun", 64'(err_overrun), 64'd0);
      rst = 1'b0;
      tick();

      // Directed frame: bit5, bit5|bit200, bit255
      begin_frame();
      check("busy_in_accum", 64'(busy), 64'd1);
      beat(onehot(5), 1'b0);
      beat(onehot(5) | onehot(200), 1'b0);
      beat(onehot(255), 1'b1);
      check("rd_valid_latency", 64'(rd_valid), 64'd1);
      wait_drain();
      check("busy_after_frame", 64'(busy), 64'd0);
      check("done_after_frame", 64'(done), 64'd0);

      // All-ones single beat
      begin_frame();
      beat({NE{1'b1}}, 1'b1);
      wait_drain();

      // Stalling consumer
      ready_mode = 1;
      rdy_phase  = 0;
      random_frame(4, 1'b1);
      ready_mode = 0;

      // Abort during DRAIN at word 3 with a coincident voxel beat
      begin_frame();
      beat(rand_mask(1'b0), 1'b0);
      beat(onehot(1), 1'b1);
      repeat (3) tick();
      check("abort_at_index3", 64'(rd_index), 64'd3);
      start        = 1'b1;
      vox_valid    = 1'b1;
      edge_mask_in = onehot(77);
      tick();
      start     = 1'b0;
      vox_valid = 1'b0;
      exp_q.delete();
      sum_q.delete();
      model_bm  = '0;
      model_cnt = 0;
      check("abort_rd_valid", 64'(rd_valid), 64'd0);
      check("abort_vox_count", 64'(vox_count), 64'd0);
      check("abort_blocked_count", 64'(blocked_count), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_busy", 64'(busy), 64'd1);
      beat(onehot(10), 1'b1);
      wait_drain();

      // Overrun in IDLE
      vox_valid    = 1'b1;
      edge_mask_in = rand_mask(1'b0);
      tick();
      vox_valid = 1'b0;
      check("idle_err_overrun", 64'(err_overrun), 64'd1);
      check("idle_rd_valid", 64'(rd_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      begin_frame();
      check("start_clears_err", 64'(err_overrun), 64'd0);
      beat(onehot(3), 1'b1);
      wait_drain();

      // Saturation on the 4-bit instance: 20 beats
      random_frame(20, 1'b1);

      // Random frames with random backpressure
      ready_mode = 2;
      for (int f = 0; f < 6; f++) begin
         random_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      end
      ready_mode = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish before timeout");
      $fatal(1, "watchdog");
   end

endmodule
